// File: rtl/bf16_adder_arbiter.sv
// bf16_adder_arbiter: round-robin arbiter that shares one external bfloat16
// adder between N_REQ requesters, one operation in flight at a time.
// Optional feature: define BF16_ARB_TIMEOUT_EN to enable the WAIT-state
// watchdog. On expiry, the arbiter returns a quiet NaN with resp_error set.
module bf16_adder_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [15:0]          resp_sum,
  output logic                 resp_error,
  output logic                 add_start,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic                 add_done,
  input  logic [15:0]          add_sum,
  output logic                 busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Elaboration-time guard on the legal parameter range
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("bf16_adder_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic                 add_start_q;
  logic [15:0]          add_a_q;
  logic [15:0]          add_b_q;
  logic [N_REQ-1:0]     resp_valid_q;
  logic [15:0]          resp_sum_q;
  logic                 busy_q;

  logic [15:0]          a_arr [N_REQ];
  logic [15:0]          b_arr [N_REQ];
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;
  logic [N_REQ-1:0]     req_ready_c;

`ifdef BF16_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]     cnt_q;
  logic                 resp_error_q;
`endif

  // Split the flat operand buses into per-requester lanes
  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_lanes
    assign a_arr[i] = req_a[16*i +: 16];
    assign b_arr[i] = req_b[16*i +: 16];
  end

  // Round-robin winner search starting at ptr; grants only while IDLE
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready_c = '0;
    if (state_q == IDLE) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
      if (grant_found) begin
        req_ready_c[grant_idx] = 1'b1;
      end
    end
  end

  // Control FSM with registered adder-issue and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      add_start_q  <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      busy_q       <= 1'b0;
`ifdef BF16_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_error_q <= 1'b0;
`endif
    end else begin
      add_start_q  <= 1'b0;
      resp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (grant_found) begin
            owner_q     <= grant_idx;
            add_a_q     <= a_arr[grant_idx];
            add_b_q     <= b_arr[grant_idx];
            add_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef BF16_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (add_done) begin
            resp_sum_q   <= add_sum;
            resp_valid_q <= N_REQ'(1) << owner_q;
            state_q      <= RESP;
          end
`ifdef BF16_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            resp_sum_q   <= 16'h7FC0;
            resp_error_q <= 1'b1;
            resp_valid_q <= N_REQ'(1) << owner_q;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          ptr_q   <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef BF16_ARB_TIMEOUT_EN
          resp_error_q <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_c;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign add_start  = add_start_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign busy       = busy_q;
`ifdef BF16_ARB_TIMEOUT_EN
  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// tb_bf16_adder_arbiter: randomized bench with a transaction-level
// round-robin model; the bench also plays the external adder.
module tb_bf16_adder_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_a;
  logic [16*N-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [15:0]       resp_sum;
  logic              resp_error;
  logic              add_start;
  logic [15:0]       add_a;
  logic [15:0]       add_b;
  logic              add_done;
  logic [15:0]       add_sum;
  logic              busy;

  always #5 clock = ~clock;

  bf16_adder_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_sum   (resp_sum),
    .resp_error (resp_error),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_done   (add_done),
    .add_sum    (add_sum),
    .busy       (busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] opa [N];
  logic [15:0] opb [N];
  int          m_ptr;
  logic [15:0] m_last_sum;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // First valid requester at or after ptr, wrapping
  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 0; k < int'(N); k++) begin
      if (m[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < int'(N); i++) begin
      req_a[16*i +: 16] = opa[i];
      req_b[16*i +: 16] = opb[i];
    end
  endtask

  // One full transaction; called at a negedge while the DUT is idle.
  // delay = extra WAIT cycles before add_done; to = adder never answers.
  task automatic run_txn(input logic [N-1:0] mask, input int delay,
                         input logic [15:0] sum, input bit to);
    int          w;
    logic [15:0] ea, eb;
    req_valid = mask;
    drive_ops();
    #1;
    w = rr_pick(m_ptr, mask);
    check("grant", 32'(req_ready), 32'(1) << w);
    check("busy_idle", 32'(busy), 32'd0);
    ea = opa[w];
    eb = opb[w];
    @(negedge clock);
    check("add_start_pulse", 32'(add_start), 32'd1);
    check("add_a", 32'(add_a), 32'(ea));
    check("add_b", 32'(add_b), 32'(eb));
    check("ready_off_busy", 32'(req_ready), 32'd0);
    check("busy_on", 32'(busy), 32'd1);
    opa[w] = 16'($urandom);
    opb[w] = 16'($urandom);
    drive_ops();
    @(negedge clock);
    check("add_start_single", 32'(add_start), 32'd0);
    check("add_a_hold", 32'(add_a), 32'(ea));
    check("add_b_hold", 32'(add_b), 32'(eb));
    repeat (delay) begin
      check("no_early_resp", 32'(resp_valid), 32'd0);
      req_valid = N'($urandom);
      #1;
      check("ready_off_wait", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    if (!to) begin
      add_done = 1'b1;
      add_sum  = sum;
      @(negedge clock);
      add_done = 1'b0;
      add_sum  = 16'($urandom);
      check("resp_valid", 32'(resp_valid), 32'(1) << w);
      check("resp_sum", 32'(resp_sum), 32'(sum));
      check("resp_error", 32'(resp_error), 32'd0);
      m_last_sum = sum;
    end else begin
      check("to_resp_valid", 32'(resp_valid), 32'(1) << w);
      check("to_resp_sum", 32'(resp_sum), 32'h7FC0);
      check("to_resp_error", 32'(resp_error), 32'd1);
      m_last_sum = 16'h7FC0;
    end
    check("busy_resp", 32'(busy), 32'd1);
    req_valid = mask;
    @(negedge clock);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
    m_ptr = (w + 1) % int'(N);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    add_done  = 1'b0;
    add_sum   = '0;
    for (int i = 0; i < int'(N); i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
    end
    drive_ops();
    m_ptr      = 0;
    m_last_sum = 16'h0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_sum", 32'(resp_sum), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_add_start", 32'(add_start), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);

    // 1.0 + 2.0 = 3.0 from requester 0, adder answers three cycles after start
    opa[0] = 16'h3F80;
    opb[0] = 16'h4000;
    run_txn(4'b0001, 2, 16'h4040, 1'b0);

    // ptr=1 with only req2/req3 pending: req2 then req3
    run_txn(4'b1100, $urandom_range(0, 3), 16'($urandom), 1'b0);
    run_txn(4'b1100, $urandom_range(0, 3), 16'($urandom), 1'b0);

    // All requesters continuously valid: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, $urandom_range(0, 3), 16'($urandom), 1'b0);
    end

    // Spurious add_done while idle with nothing pending
    req_valid = '0;
    add_done  = 1'b1;
    add_sum   = 16'hBEEF;
    @(negedge clock);
    add_done = 1'b0;
    check("spurious_resp_valid", 32'(resp_valid), 32'd0);
    check("spurious_busy", 32'(busy), 32'd0);
    check("spurious_sum_held", 32'(resp_sum), 32'(m_last_sum));
    @(negedge clock);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 5),
              16'($urandom), 1'b0);
    end

    // Reset during WAIT, late add_done must be dropped
    req_valid = 4'b0010;
    drive_ops();
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_sum", 32'(resp_sum), 32'd0);
    @(negedge clock);
    add_done = 1'b1;
    add_sum  = 16'h1234;
    @(negedge clock);
    add_done = 1'b0;
    check("late_done_resp_valid", 32'(resp_valid), 32'd0);
    check("late_done_busy", 32'(busy), 32'd0);
    m_ptr      = 0;
    m_last_sum = 16'h0000;
    run_txn(4'b1000, 1, 16'($urandom), 1'b0);
    check("ptr_after_req3_picks_0", 32'(rr_pick(m_ptr, 4'b1111)), 32'd0);

`ifdef BF16_ARB_TIMEOUT_EN
    // Adder never answers: watchdog response after TO WAIT cycles
    run_txn(4'b0100, int'(TO), 16'h0000, 1'b1);
    req_valid = '0;
    add_done  = 1'b1;
    add_sum   = 16'h5555;
    @(negedge clock);
    add_done = 1'b0;
    check("to_late_resp_valid", 32'(resp_valid), 32'd0);
    check("to_late_busy", 32'(busy), 32'd0);
    check("to_late_sum_held", 32'(resp_sum), 32'h7FC0);
`endif

    req_valid = '0;
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bf16_adder_arbiter.md
BF16_ADDER_ARBITER -- requirements
Module: bf16_adder_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles, used only with BF16_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clock  in  1: single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  N_REQ: per-requester operation request.
REQ-006 SHALL have ports req_a, req_b  in  16*N_REQ: bfloat16 operands; requester i uses bits [16i+15:16i].
REQ-007 SHALL have port req_ready  out  N_REQ: one-hot grant; an operation transfers when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-008 SHALL have port resp_valid  out  N_REQ: one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port resp_sum  out  16: result of the operation; holds its last value between responses.
REQ-010 SHALL have port resp_error  out  1: timeout flag, qualified by resp_valid.
REQ-011 SHALL have ports add_start  out  1, add_a  out  16 and add_b  out  16: issue interface to the shared bfloat16 adder.
REQ-012 SHALL have ports add_done  in  1 and add_sum  in  16: adder completion pulse and result.
REQ-013 SHALL have port busy  out  1: high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-015 SHALL, in IDLE with any req_valid high, assert combinationally the req_ready bit of the round-robin winner only: search starts at ptr, ascending, wrapping from N_REQ-1 to 0.
REQ-016 SHALL, on the handshake edge, latch the winner's operands and its index (owner), then go to ISSUE.
REQ-017 SHALL hold req_ready all-zero outside IDLE; requesters hold req_valid and operands stable until granted.
REQ-018 SHALL, in ISSUE, drive add_start=1 for exactly one cycle with add_a/add_b set to the latched operands, then go to WAIT.
REQ-019 SHALL, in WAIT, hold add_a/add_b stable; on add_done=1, capture add_sum into resp_sum and go to RESP.
REQ-020 SHALL ignore add_done in IDLE, ISSUE and RESP.
REQ-021 SHALL, in RESP, pulse resp_valid[owner] for one cycle with resp_sum valid, set ptr=(owner+1) mod N_REQ, and return to IDLE.
REQ-022 SHALL not support response backpressure.
REQ-023 SHALL give a minimum latency of handshake at cycle T, add_start at T+1, and resp_valid at T+3 when add_done arrives at T+2; the next grant is at T+4 at the earliest.
REQ-024 SHALL update ptr only on completion.
REQ-025 SHALL ignore req_valid toggling while ungranted and the owner's req_valid during its own transaction.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, ptr=0, owner=0, all outputs=0 and resp_sum=16'h0000.
REQ-027 SHALL, on reset asserted mid-operation, discard the in-flight operation; no resp_valid is produced and a later add_done is ignored.

Configuration
REQ-028 SHALL, with macro BF16_ARB_TIMEOUT_EN defined, count WAIT cycles from the cycle after add_start; on reaching TIMEOUT without add_done, go to RESP with resp_sum=16'h7FC0 and resp_error=1.
REQ-029 SHALL, with BF16_ARB_TIMEOUT_EN defined, have add_done arriving after a timeout ignored per REQ-020.
REQ-030 SHALL, without BF16_ARB_TIMEOUT_EN, have no counter; WAIT lasts indefinitely and resp_error is tied 0.

Verification
REQ-031 SHALL cover: req0 a=16'h3F80, b=16'h4000, model returns add_done with add_sum=16'h4040 three cycles after start -> one add_start pulse, resp_valid[0] one cycle, resp_sum=16'h4040, resp_error=0.
REQ-032 SHALL cover: all four req_valid held high continuously -> grant order 0,1,2,3,0, each transaction completing before the next grant.
REQ-033 SHALL cover: req0 served, then only req2 and req3 valid -> req2 granted first (ptr=1 skips idle req1), then req3.
REQ-034 SHALL cover: reset pulsed in WAIT, with add_done arriving two cycles later -> no resp_valid; the next request from req3 alone is granted with ptr=0.
REQ-035 SHALL cover: TIMEOUT=8, macro defined, add_done never returned -> resp_valid[owner] with resp_sum=16'h7FC0 and resp_error=1, 8 cycles after WAIT entry; a late add_done causes no effect.
REQ-036 SHALL cover: spurious add_done in IDLE with no requests -> no resp_valid, busy stays 0.
